led_fade: RTL and testbench

Output stage placed directly downstream of the two-LED flow pattern generator. It consumes the generator's 2-bit level pattern and drives the physical LED pins through per-channel PWM. Each channel's brightness ramps linearly toward fully on or fully off instead of switching hard, which turns the flowing pattern into a cross-fade.

---
 rtl/led_fade.sv | 95 +++++++++
 tb/tb_led_fade.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade.sv
// led_fade: per-channel linear brightness ramp plus PWM drive for a two-LED
// flow pattern. Each channel's duty walks one step per prescaler tick toward
// fully on or fully off, so hard pattern switches become a cross-fade.
module led_fade #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 49000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] led_in,
  output logic [1:0] led_out,
  output logic       busy
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1'b1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = MAX - PWM_ONE;
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1'b1);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic [1:0]                led_q;
  logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [1:0][PWM_BITS-1:0]  duty_q, duty_d;
  logic [1:0]                led_out_q, led_out_d;
  logic [1:0][PWM_BITS-1:0]  tgt;
  logic                      tick;

  // Brightness target per channel and the prescaler step strobe.
  always_comb begin
    tick = (div_cnt_q == DIV_LAST);
    for (int i = 0; i < 2; i++) begin
      if (led_q[i]) begin
        tgt[i] = MAX;
      end else begin
        tgt[i] = '0;
      end
    end
  end

  // Next-state for prescaler, PWM counter, duty ramps and PWM compare.
  always_comb begin
    if (tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
    end

    // The PWM period is MAX cycles so that duty == MAX is a constant high.
    if (pwm_cnt_q == PWM_LAST) begin
      pwm_cnt_d = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + PWM_ONE;
    end

    for (int i = 0; i < 2; i++) begin
      led_out_d[i] = (pwm_cnt_q < duty_q[i]);
      duty_d[i]    = duty_q[i];
      if (tick) begin
        // Step by one and saturate; a reversed target simply reverses the walk.
        if (led_q[i] && (duty_q[i] != MAX)) begin
          duty_d[i] = duty_q[i] + PWM_ONE;
        end else if (!led_q[i] && (duty_q[i] != '0)) begin
          duty_d[i] = duty_q[i] - PWM_ONE;
        end else begin
          duty_d[i] = duty_q[i];
        end
      end else begin
        duty_d[i] = duty_q[i];
      end
    end
  end

  // State registers; reset clears everything, overriding tick and input changes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led_q     <= 2'b00;
      div_cnt_q <= '0;
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      led_out_q <= 2'b00;
    end else begin
      led_q     <= led_in;
      div_cnt_q <= div_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      led_out_q <= led_out_d;
    end
  end

  assign led_out = led_out_q;
  assign busy    = (duty_q[0] != tgt[0]) | (duty_q[1] != tgt[1]);

endmodule

// File: tb/tb_led_fade.sv
// Bench for led_fade with PWM_BITS=3 (MAX=7) and STEP_DIV=4. A cycle-level
// reference model derived from elapsed-cycle arithmetic tracks the expected
// duties, outputs and prescaler; each scenario also checks its own closed-form
// expectations.
module tb_led_fade;

  localparam int PB = 3;
  localparam int SD = 4;
  localparam int MX = 7;

  logic       sys_clk;
  logic       sys_rst;
  logic [1:0] led_in;
  logic [1:0] led_out;
  logic       busy;

  int total;
  int bad;

  // reference model state
  int         m_n;      // cycles since reset release edge
  logic [1:0] m_ledq;
  int         m_duty[2];
  logic [1:0] m_out;

  logic [10:0] obs;

  led_fade #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .led_in  (led_in),
    .led_out (led_out),
    .busy    (busy)
  );

  assign obs = {led_out, busy, dut.duty_q[0], dut.duty_q[1], dut.div_cnt_q};

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [10:0] exp_vec();
    logic b;
    b = (m_duty[0] != (m_ledq[0] ? MX : 0)) || (m_duty[1] != (m_ledq[1] ? MX : 0));
    return {m_out, b, 3'(m_duty[0]), 3'(m_duty[1]), 2'(m_n % SD)};
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, settle.
  task automatic cycle(input logic rst, input logic [1:0] li);
    int pwm;
    bit tk;
    sys_rst = rst;
    led_in  = li;
    @(posedge sys_clk);
    if (rst) begin
      m_n = 0; m_ledq = 2'b00; m_duty[0] = 0; m_duty[1] = 0; m_out = 2'b00;
    end else begin
      tk  = ((m_n % SD) == SD - 1);
      pwm = m_n % MX;
      for (int i = 0; i < 2; i++) m_out[i] = (pwm < m_duty[i]);
      if (tk) begin
        for (int i = 0; i < 2; i++) begin
          if (m_ledq[i] && m_duty[i] < MX) m_duty[i] = m_duty[i] + 1;
          else if (!m_ledq[i] && m_duty[i] > 0) m_duty[i] = m_duty[i] - 1;
        end
      end
      m_ledq = li;
      m_n = m_n + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 2'b11);
      total++;
      if ({led_out, busy} !== 3'b000) begin
        bad++;
        $display("FAIL reset_outputs got out=%b busy=%b want out=00 busy=0", led_out, busy);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b0, 2'b11);
      total++;
      if (obs[7:2] !== ((k == 4) ? 6'b001_001 : 6'b000_000)) begin
        bad++;
        $display("FAIL reset_first_tick k=%0d got duties=%b want %b", k, obs[7:2],
                 (k == 4) ? 6'b001_001 : 6'b000_000);
      end
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL reset_model got %b want %b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_ramp_up();
    int d0;
    cycle(1'b1, 2'b00);
    for (int k = 1; k <= 128; k++) begin
      cycle(1'b0, 2'b01);
      d0 = (k / SD < MX) ? k / SD : MX;
      total++;
      if ({obs[8:2]} !== {(d0 != MX), 3'(d0), 3'b000}) begin
        bad++;
        $display("FAIL ramp_up k=%0d got busy/d0/d1=%b want %b", k, obs[8:2],
                 {(d0 != MX), 3'(d0), 3'b000});
      end
      if (k >= 29) begin
        total++;
        if (led_out !== 2'b01) begin
          bad++;
          $display("FAIL ramp_up_full k=%0d got out=%b want 01", k, led_out);
        end
      end
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL ramp_up_model k=%0d got %b want %b", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_pwm();
    cycle(1'b1, 2'b00);
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b0, (k <= 12) ? 2'b01 : 2'b00);
      if (k >= 12 && k <= 15) begin
        total++;
        if (obs[7:5] !== 3'd3) begin
          bad++;
          $display("FAIL pwm_duty k=%0d got d0=%0d want 3", k, obs[7:5]);
        end
      end
      if (k >= 13 && k <= 16) begin
        total++;
        if (led_out[0] !== (((k - 1) % MX) < 3)) begin
          bad++;
          $display("FAIL pwm_shape k=%0d got %b want %b", k, led_out[0], (((k - 1) % MX) < 3));
        end
      end
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL pwm_model k=%0d got %b want %b", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_crossfade();
    int t;
    int e0;
    int e1;
    cycle(1'b1, 2'b00);
    for (int k = 1; k <= 60; k++) begin
      cycle(1'b0, (k <= 16) ? 2'b01 : 2'b10);
      if (k == 16) begin
        total++;
        if (obs[7:5] !== 3'd4) begin
          bad++;
          $display("FAIL xfade_start got d0=%0d want 4", obs[7:5]);
        end
      end
      if (k >= 17) begin
        t  = (k - 16) / SD;
        e0 = (4 - t > 0) ? 4 - t : 0;
        e1 = (t < MX) ? t : MX;
        total++;
        if (obs[8:2] !== {(e1 != MX), 3'(e0), 3'(e1)}) begin
          bad++;
          $display("FAIL xfade k=%0d got busy/d0/d1=%b want %b", k, obs[8:2],
                   {(e1 != MX), 3'(e0), 3'(e1)});
        end
      end
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL xfade_model k=%0d got %b want %b", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 2'b00);
    for (int k = 1; k <= 23; k++) begin
      cycle(1'b0, (k <= 12) ? 2'b01 : 2'b11);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL rstmid_model k=%0d got %b want %b", k, obs, exp_vec());
      end
    end
    total++;
    if (obs[7:0] !== {3'd5, 3'd2, 2'd3}) begin
      bad++;
      $display("FAIL rstmid_setup got d0/d1/div=%b want %b", obs[7:0], {3'd5, 3'd2, 2'd3});
    end
    cycle(1'b1, 2'b10);
    total++;
    if (obs !== 11'b0) begin
      bad++;
      $display("FAIL rstmid_clear got %b want 00000000000", obs);
    end
    cycle(1'b0, 2'b10);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_busy got %b want 1", busy);
    end
  endtask

  task automatic test_zero();
    cycle(1'b1, 2'b00);
    for (int k = 1; k <= 50; k++) begin
      cycle(1'b0, 2'b00);
      total++;
      if (obs[10:2] !== 9'b0) begin
        bad++;
        $display("FAIL zero_hold k=%0d got out/busy/d0/d1=%b want 000000000", k, obs[10:2]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] li;
    logic       r;
    li = 2'b00;
    cycle(1'b1, li);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) li = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 59) == 0);
      cycle(r, li);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL random k=%0d got %b want %b", k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    sys_rst = 1'b1;
    led_in  = 2'b00;
    m_n = 0; m_ledq = 2'b00; m_duty[0] = 0; m_duty[1] = 0; m_out = 2'b00;
    test_reset();
    test_ramp_up();
    test_pwm();
    test_crossfade();
    test_reset_mid();
    test_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
